klein_96_byte_io: RTL and testbench
===================================

KLEIN_96_BYTE_IO -- requirements
Module: klein_96_byte_io

Interface
REQ-001 The block SHALL have these parameters: WDOG, default 31, the maximum number of cycles to wait for core_ready in RUN; BYTES_KEY, fixed 12; BYTES_TXT, fixed 8.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- ck, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input byte present.
- in_ready, out, 1: block accepts an input byte.
- in_data, in, 8: input byte.
- out_valid, out, 1: ciphertext byte present.
- out_ready, in, 1: consumer accepts a ciphertext byte.
- out_data, out, 8: ciphertext byte.
- busy, out, 1: a job is in progress (any state other than LOAD).
- err, out, 1: sticky watchdog error.
- core_start, out, 1: start pulse to the KLEIN-96 core.
- core_inp, out, 64 ([0:63]): plaintext to the core.
- core_key, out, 96 ([0:95]): key to the core.
- core_ready, in, 1: core round-19 indication.
- core_out, in, 64 ([0:63]): core ciphertext.
REQ-003 There SHALL be one clock, ck, and reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 A job SHALL consist of 20 input bytes: 12 key bytes, then 8 plaintext bytes. The first key byte maps to core_key[0:7] and the last to core_key[88:95]. The first plaintext byte maps to core_inp[0:7].
REQ-005 An input byte SHALL transfer on a ck edge with in_valid=1 and in_ready=1; an output byte SHALL transfer on an edge with out_valid=1 and out_ready=1.
REQ-006 The FSM states SHALL be LOAD, START, RUN and SEND.
REQ-007 LOAD: in_ready=1. A 5-bit byte counter increments on each transfer. The transfer that brings the count to 20 moves the FSM to START and clears the counter.
REQ-008 START: lasts exactly one cycle with core_start=1 and core_key/core_inp held stable from the assembled registers. The FSM then moves to RUN.
REQ-009 RUN:
- A wait counter starts at 0 on the first RUN cycle and increments each cycle.
- If core_ready=1 on an edge, core_out is captured into a 64-bit output shift register and the FSM moves to SEND.
- If the wait counter reaches WDOG without core_ready, err is set to 1 and the FSM returns to LOAD.
REQ-010 With a conforming core, core_ready SHALL be sampled high on the 19th edge after the edge that sampled core_start=1.
REQ-011 core_ready SHALL be ignored in LOAD, START and SEND. The core's round counter free-runs and wraps, so it can raise core_ready spuriously.
REQ-012 SEND:
- out_valid=1 and out_data = shift register bits [0:7].
- On each output transfer the register shifts left by 8.
- The 8th transfer returns the FSM to LOAD.
- While out_ready=0, out_data and out_valid hold.
REQ-013 in_ready SHALL be 0 in START, RUN and SEND. in_valid is ignored in those states, and no byte is lost or counted.
REQ-014 core_start SHALL be 0 in every state except START.
REQ-015 Throughput: the first ciphertext byte SHALL be presented on the cycle after capture. The minimum job time, from the first in-byte edge to the last out-byte edge, is 20 + 1 + 19 + 8 edges.
REQ-016 err SHALL be cleared only by reset. A new job is accepted with err=1.
REQ-017 core_key and core_inp SHALL change only on LOAD transfers.

Reset
REQ-018 rst_n=0 SHALL immediately force the following, including in the middle of any state:
- FSM = LOAD and byte counter = 0.
- Wait counter = 0 and err = 0.
- Key, plaintext and output registers all 0.
- Outputs: core_start=0, out_valid=0, out_data=0x00, busy=0, and in_ready=1 once rst_n=1.
REQ-019 A partial job in progress at reset SHALL be discarded. The first byte after reset is key byte 0.

Verification
REQ-020 Vector: 12 bytes 0x00, then 8 bytes 0xFF, stalls-free, with a real klein_96 attached -> core_start is high for exactly 1 cycle and out bytes are DB 9F A7 D3 3D 8E 8E 36.
REQ-021 Back-to-back input: in_valid held 1 during RUN/SEND -> in_ready=0; bytes of the second job are accepted only after the 8th out byte, and the second job's result is correct.
REQ-022 out_ready toggled 1/0 randomly in SEND -> the byte sequence is unchanged, and each byte is held stable while out_ready=0.
REQ-023 Stub core that never asserts core_ready -> err=1 after WDOG+1 RUN cycles, FSM in LOAD, in_ready=1, no out_valid.
REQ-024 Stub core pulsing core_ready during LOAD -> no capture, no out_valid, and the byte count is unaffected.
REQ-025 rst_n pulsed low after 7 input bytes, and again in SEND after 3 output bytes -> all outputs are at reset values immediately; a fresh 20-byte job then yields the correct ciphertext.

Source files
------------

// File: rtl/klein_96_byte_io.sv
// Byte-serial wrapper around a KLEIN-96 core: collects 12 key bytes and 8 plaintext
// bytes, starts the core, waits for it under a watchdog and streams out 8 ciphertext bytes.
module klein_96_byte_io #(
  parameter int unsigned WDOG      = 31,
  parameter int unsigned BYTES_KEY = 12,
  parameter int unsigned BYTES_TXT = 8
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        err,
  output logic        core_start,
  output logic [0:63] core_inp,
  output logic [0:95] core_key,
  input  logic        core_ready,
  input  logic [0:63] core_out
);

  localparam int unsigned JOB_BYTES = BYTES_KEY + BYTES_TXT;
  localparam int unsigned WW        = (WDOG == 0) ? 1 : $clog2(WDOG + 1);

  typedef enum logic [1:0] {
    LOAD,
    START,
    RUN,
    SEND
  } state_t;

  state_t          r_state;
  logic [4:0]      r_bcnt;
  logic [2:0]      r_ocnt;
  logic [WW-1:0]   r_wait;
  logic [0:95]     r_key;
  logic [0:63]     r_inp;
  logic [0:63]     r_out;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_err;
  logic            r_start;

  logic            w_in_xfer;
  logic            w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out[0:7];
  assign busy       = r_busy;
  assign err        = r_err;
  assign core_start = r_start;
  assign core_key   = r_key;
  assign core_inp   = r_inp;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_bcnt      <= '0;
      r_ocnt      <= '0;
      r_wait      <= '0;
      r_key       <= '0;
      r_inp       <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_xfer) begin
            // Bytes shift in from the right so the first byte of each field ends up at bit 0.
            if (r_bcnt < 5'(BYTES_KEY)) begin
              r_key <= {r_key[8:95], in_data};
            end else begin
              r_inp <= {r_inp[8:63], in_data};
            end
            if (r_bcnt == 5'(JOB_BYTES - 1)) begin
              r_bcnt     <= '0;
              r_state    <= START;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_start    <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + 5'd1;
            end
          end
        end

        START: begin
          r_start <= 1'b0;
          r_wait  <= '0;
          r_state <= RUN;
        end

        RUN: begin
          if (core_ready) begin
            r_out       <= core_out;
            r_out_valid <= 1'b1;
            r_ocnt      <= '0;
            r_state     <= SEND;
          end else if (r_wait == WW'(WDOG)) begin
            r_err      <= 1'b1;
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end

        SEND: begin
          if (w_out_xfer) begin
            r_out  <= {r_out[8:63], 8'h00};
            r_ocnt <= r_ocnt + 3'd1;
            if (r_ocnt == 3'd7) begin
              r_out_valid <= 1'b0;
              r_state     <= LOAD;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_klein_96_byte_io.sv
// Randomised bench for klein_96_byte_io: a stub KLEIN core plus a cycle-timed
// transaction model predicting handshakes, start pulse, ciphertext order and watchdog.
module tb_klein_96_byte_io;

  localparam int unsigned WDOG_TB = 31;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        err;
  logic        core_start;
  logic [0:63] core_inp;
  logic [0:95] core_key;
  logic        core_ready;
  logic [0:63] core_out;

  always #5 ck = ~ck;

  klein_96_byte_io #(
    .WDOG(WDOG_TB)
  ) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err),
    .core_start (core_start),
    .core_inp   (core_inp),
    .core_key   (core_key),
    .core_ready (core_ready),
    .core_out   (core_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Stub core. Mode 0: answers 19 edges after start; 1: never answers;
  // 2: like 0 but also raises core_ready at random outside RUN.
  int          core_mode = 0;
  int          cd;
  logic [0:63] cres;
  logic        spur = 1'b0;

  function automatic logic [0:63] ref_core(input logic [0:95] k, input logic [0:63] p);
    if (k == '0 && p == '1) return 64'hDB9FA7D33D8E8E36;
    return ((p ^ k[0:63]) * 64'h9E3779B97F4A7C15) ^ {k[64:95], ~k[64:95]};
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cd   <= 0;
      cres <= '0;
    end else if (core_start) begin
      cd   <= 19;
      cres <= ref_core(core_key, core_inp);
    end else if (cd != 0) begin
      cd <= cd - 1;
    end
  end

  always @(negedge ck) spur = ($urandom_range(0, 2) == 0);

  assign core_ready = (core_mode != 1 && cd == 1) ||
                      (core_mode == 2 && spur && !(busy && !core_start && !out_valid));
  assign core_out   = cres;

  // Byte feeder and consumer
  logic [7:0] feed_q[$];
  int         vpct = 100;
  int         rpct = 100;

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    forever begin
      @(posedge ck);
      #1;
      if (feed_q.size() > 0 && $urandom_range(1, 100) <= vpct) begin
        in_valid = 1'b1;
        in_data  = feed_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(1, 100) <= rpct);
      @(negedge ck);
      if (in_valid && in_ready && rst_n && feed_q.size() > 0) void'(feed_q.pop_front());
    end
  end

  // Transaction model, evaluated once per cycle on the falling edge
  int          cyc = 0;
  bit          accepting = 1'b1;
  logic [7:0]  jb[$];
  logic [0:95] mk;
  logic [0:63] mp;
  logic [0:63] ct;
  int          start_cyc = -1;
  int          send_cyc = -1;
  int          err_cyc = -1;
  int          resume_cyc = -1;
  bit          sending = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          err_exp = 1'b0;
  int          sent = 0;
  logic [0:95] prev_key = '0;
  logic [0:63] prev_inp = '0;
  bit          prev_took = 1'b0;
  int          start_hi = 0;
  int          run_cyc = 0;

  initial begin
    forever begin
      @(negedge ck);
      cyc++;
      if (!rst_n) begin
        accepting  = 1'b1;
        jb.delete();
        exp_q.delete();
        start_cyc  = -1;
        send_cyc   = -1;
        err_cyc    = -1;
        resume_cyc = -1;
        sending    = 1'b0;
        sent       = 0;
        err_exp    = 1'b0;
        prev_key   = '0;
        prev_inp   = '0;
        prev_took  = 1'b0;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst core_start", core_start, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst out_data", out_data, 8'h00);
        chk("rst err", err, 1'b0);
      end else begin
        if (cyc == send_cyc) sending = 1'b1;
        if (cyc == err_cyc) begin
          accepting = 1'b1;
          err_exp   = 1'b1;
        end
        if (cyc == resume_cyc) accepting = 1'b1;

        chk("in_ready", in_ready, accepting);
        chk("busy", busy, !accepting);
        chk("core_start", core_start, cyc == start_cyc);
        chk("out_valid", out_valid, sending);
        chk("out_data", out_data, (sending && exp_q.size() > 0) ? exp_q[0] : 8'h00);
        chk("err", err, err_exp);
        if (!prev_took) begin
          chk("core_key hold", core_key, prev_key);
          chk("core_inp hold", core_inp, prev_inp);
        end
        if (cyc == start_cyc) begin
          chk("core_key at start", core_key, mk);
          chk("core_inp at start", core_inp, mp);
        end
        if (core_start) start_hi++;
        if (busy && !core_start && !out_valid) run_cyc++;
        prev_key = core_key;
        prev_inp = core_inp;

        // Predict what the coming edge does
        prev_took = accepting && in_valid;
        if (prev_took) begin
          jb.push_back(in_data);
          if (jb.size() == 20) begin
            for (int i = 0; i < 12; i++) mk[8*i +: 8] = jb[i];
            for (int i = 0; i < 8; i++) mp[8*i +: 8] = jb[12 + i];
            jb.delete();
            accepting = 1'b0;
            start_cyc = cyc + 1;
            if (core_mode == 1) begin
              err_cyc = cyc + 3 + int'(WDOG_TB);
            end else begin
              send_cyc = cyc + 21;
              ct = ref_core(mk, mp);
              for (int i = 0; i < 8; i++) exp_q.push_back(ct[8*i +: 8]);
            end
          end
        end
        if (sending && out_ready) begin
          got_q.push_back(out_data);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          sent++;
          if (sent == 8) begin
            sending    = 1'b0;
            sent       = 0;
            resume_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic push_job(input logic [0:95] k, input logic [0:63] p);
    for (int i = 0; i < 12; i++) feed_q.push_back(k[8*i +: 8]);
    for (int i = 0; i < 8; i++) feed_q.push_back(p[8*i +: 8]);
  endtask

  task automatic push_rand_job();
    logic [0:95] k;
    logic [0:63] p;
    k = {$urandom, $urandom, $urandom};
    p = {$urandom, $urandom};
    push_job(k, p);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(posedge ck);
      n++;
    end while (!(accepting && feed_q.size() == 0 && !sending && jb.size() == 0) && n < max_cyc);
    chk("idle timeout", n < max_cyc, 1'b1);
  endtask

  task automatic chk_reset_now();
    chk("async rst out_valid", out_valid, 1'b0);
    chk("async rst core_start", core_start, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst out_data", out_data, 8'h00);
    chk("async rst err", err, 1'b0);
    chk("async rst core_key", core_key, 96'h0);
    chk("async rst core_inp", core_inp, 64'h0);
  endtask

  task automatic pulse_reset();
    @(posedge ck);
    #2;
    rst_n = 1'b0;
    feed_q.delete();
    #1;
    chk_reset_now();
    repeat (2) @(posedge ck);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] g;
    int          n;
    rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #3;
    rst_n = 1'b1;

    // Published vector: all-zero key, all-ones plaintext, no stalls
    start_hi = 0;
    got_q.delete();
    push_job('0, '1);
    wait_idle(300);
    chk("vector start cycles", start_hi, 1);
    chk("vector byte count", got_q.size(), 8);
    g = '0;
    foreach (got_q[i]) g = {g[55:0], got_q[i]};
    chk("vector ciphertext", g, 64'hDB9FA7D33D8E8E36);

    // Byte-to-bit mapping of key and plaintext
    push_job(96'h000102030405060708090A0B, 64'h1011121314151617);
    n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!core_start && n < 200);
    chk("start timeout", n < 200, 1'b1);
    chk("key mapping", core_key, 96'h000102030405060708090A0B);
    chk("inp mapping", core_inp, 64'h1011121314151617);
    wait_idle(300);

    // Back-to-back jobs with in_valid held high, random consumer stalls
    rpct = 50;
    for (int j = 0; j < 3; j++) push_rand_job();
    wait_idle(2000);

    // Irregular producer and consumer
    vpct = 60;
    rpct = 40;
    for (int j = 0; j < 3; j++) push_rand_job();
    wait_idle(3000);
    vpct = 100;
    rpct = 100;

    // Silent core trips the watchdog after WDOG+1 RUN cycles
    core_mode = 1;
    run_cyc   = 0;
    push_rand_job();
    wait_idle(400);
    chk("wdog run cycles", run_cyc, 32);
    @(negedge ck);
    chk("wdog err", err, 1'b1);
    chk("wdog in_ready", in_ready, 1'b1);
    chk("wdog out_valid", out_valid, 1'b0);

    // Spurious core_ready outside RUN, job accepted while err is set
    core_mode = 2;
    rpct = 70;
    for (int j = 0; j < 2; j++) push_rand_job();
    wait_idle(2000);
    core_mode = 0;
    rpct = 100;

    // Reset after 7 input bytes
    push_rand_job();
    n = 0;
    while (jb.size() < 7 && n < 200) begin
      @(posedge ck);
      n++;
    end
    chk("7-byte wait", n < 200, 1'b1);
    pulse_reset();

    // Reset in SEND after 3 output bytes
    push_rand_job();
    n = 0;
    while (sent < 3 && n < 300) begin
      @(posedge ck);
      n++;
    end
    chk("3-out wait", n < 300, 1'b1);
    pulse_reset();

    // Fresh job after reset
    got_q.delete();
    push_job('0, '1);
    wait_idle(300);
    g = '0;
    foreach (got_q[i]) g = {g[55:0], got_q[i]};
    chk("post-reset ciphertext", g, 64'hDB9FA7D33D8E8E36);

    repeat (5) @(posedge ck);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
